// File: rtl/hdmi_sync_retimer.sv
// Sync retimer ahead of the hdmi encoder: locks H/V counters to the source syncs and
// regenerates registered blank/sync/RGB with an optional border test pattern and a frame lock detector.
module hdmi_sync_retimer #(
    parameter int H_OFFSET       = 68,
    parameter int H_ACTIVE       = 720,
    parameter int V_OFFSET       = 39,
    parameter int V_ACTIVE       = 576,
    parameter int HS_START       = 800,
    parameter int VS_START       = 620,
    parameter int LOCK_FRAMES    = 2,
    parameter bit BLANK_UNLOCKED = 1'b1
) (
    input  logic       I_CLK_PIXEL,
    input  logic       I_RESET_N,
    input  logic       I_HSYNC,
    input  logic       I_VSYNC,
    input  logic [7:0] I_R,
    input  logic [7:0] I_G,
    input  logic [7:0] I_B,
    input  logic       I_TEST_PATTERN,
    output logic [7:0] O_R,
    output logic [7:0] O_G,
    output logic [7:0] O_B,
    output logic       O_BLANK,
    output logic       O_HSYNC,
    output logic       O_VSYNC,
    output logic       O_LOCKED
);

    localparam logic [9:0] H_FIRST = 10'(H_OFFSET);
    localparam logic [9:0] H_LAST  = 10'(H_OFFSET + H_ACTIVE - 1);
    localparam logic [9:0] V_FIRST = 10'(V_OFFSET);
    localparam logic [9:0] V_LAST  = 10'(V_OFFSET + V_ACTIVE - 1);
    localparam logic [9:0] HS_POS  = 10'(HS_START);
    localparam logic [9:0] VS_POS  = 10'(VS_START);
    localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic [9:0] prev_len;
    logic [2:0] stable;
    logic [2:0] stable_nxt;
    logic       hs_d;
    logic       vs_d;
    logic       line_start;
    logic       frame_start;

    // Counters stick at full scale so a dead source parks in the blank/hsync-low region.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    assign line_start  = !hs_d && I_HSYNC;
    assign frame_start = line_start && !vs_d && I_VSYNC;

    always_comb begin
        stable_nxt = '0;
        if (vcnt == prev_len && vcnt != '0)
            stable_nxt = (stable >= LOCK_N) ? LOCK_N : stable + 3'd1;
    end

    always_ff @(posedge I_CLK_PIXEL or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            hcnt     <= '0;
            vcnt     <= '0;
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
            stable   <= '0;
            prev_len <= '0;
            O_LOCKED <= 1'b0;
        end else begin
            hs_d <= I_HSYNC;
            if (line_start) begin
                hcnt <= '0;
                vs_d <= I_VSYNC;
                vcnt <= frame_start ? '0 : sat_inc(vcnt);
            end else begin
                hcnt <= sat_inc(hcnt);
            end
            // vcnt still holds the line count of the frame that just ended
            if (frame_start) begin
                stable   <= stable_nxt;
                prev_len <= vcnt;
                O_LOCKED <= (stable_nxt == LOCK_N);
            end
        end
    end

    logic       active;
    logic       border;
    logic       blank;
    logic       hs_zone;
    logic [7:0] r_nxt;
    logic [7:0] g_nxt;
    logic [7:0] b_nxt;

    assign active  = hcnt >= H_FIRST && hcnt <= H_LAST && vcnt >= V_FIRST && vcnt <= V_LAST;
    assign border  = hcnt == H_FIRST || hcnt == H_LAST || vcnt == V_FIRST || vcnt == V_LAST;
    assign blank   = !active || (BLANK_UNLOCKED && !O_LOCKED);
    assign hs_zone = hcnt >= HS_POS;

    always_comb begin
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        if (!blank) begin
            if (!I_TEST_PATTERN) begin
                r_nxt = I_R;
                g_nxt = I_G;
                b_nxt = I_B;
            end else if (border) begin
                g_nxt = 8'hFF;
            end else begin
                r_nxt = 8'h80;
                g_nxt = 8'h80;
                b_nxt = 8'h80;
            end
        end
    end

    always_ff @(posedge I_CLK_PIXEL or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            O_BLANK <= 1'b1;
            O_R     <= '0;
            O_G     <= '0;
            O_B     <= '0;
            O_HSYNC <= 1'b1;
            O_VSYNC <= 1'b1;
        end else begin
            O_BLANK <= blank;
            O_R     <= r_nxt;
            O_G     <= g_nxt;
            O_B     <= b_nxt;
            O_HSYNC <= !hs_zone;
            // vsync edges are aligned to the hsync leading edge
            if (hs_zone)
                O_VSYNC <= !(vcnt >= VS_POS);
        end
    end

endmodule

// File: tb/tb_hdmi_sync_retimer.sv
// Randomized bench for hdmi_sync_retimer on a scaled-down raster (24 clk/line, 14 lines/frame),
// checked per clock against a time-stamp based reference model.
module tb_hdmi_sync_retimer;

    localparam int HO = 4, HA = 10, VO = 3, VA = 6, HS = 20, VS = 11, LF = 2;
    localparam int HT = 24, VT = 14, FR = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync = 1'b1, vsync = 1'b1, tp = 1'b0;
    logic [7:0] r = '0, g = '0, b = '0;
    logic [7:0] o_r, o_g, o_b;
    logic       o_blank, o_hs, o_vs, o_lock;

    always #5 clk = ~clk;

    hdmi_sync_retimer #(
        .H_OFFSET(HO), .H_ACTIVE(HA), .V_OFFSET(VO), .V_ACTIVE(VA),
        .HS_START(HS), .VS_START(VS), .LOCK_FRAMES(LF), .BLANK_UNLOCKED(1'b1)
    ) dut (
        .I_CLK_PIXEL(clk), .I_RESET_N(rst_n), .I_HSYNC(hsync), .I_VSYNC(vsync),
        .I_R(r), .I_G(g), .I_B(b), .I_TEST_PATTERN(tp),
        .O_R(o_r), .O_G(o_g), .O_B(o_b), .O_BLANK(o_blank),
        .O_HSYNC(o_hs), .O_VSYNC(o_vs), .O_LOCKED(o_lock)
    );

    int checks = 0, errors = 0;

    // source raster position; hsync low h=18..21, vsync low lines 10..11
    int sh = 0, sl = 0, vt_cur = VT;
    bit short_next = 0, no_hs = 0;

    // reference model: time since last line start, line starts since frame start, frame length history
    int  ecnt = 0, ls_e = 0, nls = 0;
    bit  hs_prev = 1, vs_ls = 1, m_locked = 0;
    int  lens[$];
    logic [7:0] exp_r, exp_g, exp_b;
    bit  exp_blank = 1, exp_hs = 1, exp_vs = 1;
    int  last_hc = 0, last_vc = 0;

    task automatic drive_src();
        hsync = no_hs ? 1'b1 : !(sh >= 18 && sh <= 21);
        vsync = !(sl == 10 || sl == 11);
        r = 8'($urandom);
        g = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic adv_src();
        sh++;
        if (sh == HT) begin
            sh = 0;
            sl++;
            if (sl == vt_cur) begin
                sl = 0;
                vt_cur = short_next ? VT - 1 : VT;
                short_next = 0;
            end
        end
        drive_src();
    endtask

    function automatic bit lock_ok();
        int n = lens.size();
        if (n < LF + 1) return 0;
        for (int i = n - LF - 1; i < n; i++)
            if (lens[i] != lens[n-1] || lens[i] == 0) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        ls_e = ecnt; nls = 0; hs_prev = 1; vs_ls = 1; m_locked = 0;
        lens.delete();
        lens.push_back(0);
        exp_blank = 1; exp_hs = 1; exp_vs = 1;
        exp_r = 0; exp_g = 0; exp_b = 0;
    endtask

    task automatic rst_cycle();
        @(posedge clk); #1;
        adv_src();
    endtask

    // one clock: predict post-edge outputs from pre-edge position, then advance the source
    task automatic tick();
        int hc, vc;
        bit ls, fs, act, brd;
        hc = (ecnt - ls_e > 1023) ? 1023 : ecnt - ls_e;
        vc = (nls > 1023) ? 1023 : nls;
        act = hc >= HO && hc < HO + HA && vc >= VO && vc < VO + VA;
        if (!act || !m_locked) begin
            exp_blank = 1; exp_r = 0; exp_g = 0; exp_b = 0;
        end else begin
            exp_blank = 0;
            brd = hc == HO || hc == HO + HA - 1 || vc == VO || vc == VO + VA - 1;
            if (!tp) begin
                exp_r = r; exp_g = g; exp_b = b;
            end else if (brd) begin
                exp_r = 8'h00; exp_g = 8'hFF; exp_b = 8'h00;
            end else begin
                exp_r = 8'h80; exp_g = 8'h80; exp_b = 8'h80;
            end
        end
        exp_hs = !(hc >= HS);
        if (hc >= HS) exp_vs = !(vc >= VS);
        ls = !hs_prev && hsync;
        fs = ls && !vs_ls && vsync;
        if (fs) begin
            lens.push_back(vc);
            m_locked = lock_ok();
        end
        if (ls) begin
            ls_e = ecnt + 1;
            vs_ls = vsync;
            nls = fs ? 0 : nls + 1;
        end
        hs_prev = hsync;
        ecnt++;
        last_hc = hc; last_vc = vc;
        @(posedge clk); #1;
        adv_src();
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive_src();
        model_reset();
        rst_cycle(); rst_cycle();
        checks++; if (o_blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b exp 1", o_blank); end
        checks++; if ({o_r, o_g, o_b} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h exp 000000", {o_r, o_g, o_b}); end
        checks++; if (o_hs !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", o_hs); end
        checks++; if (o_vs !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", o_vs); end
        checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", o_lock); end
        rst_n = 1;
    endtask

    task automatic test_lock();
        bit seen = 0;
        tp = 0;
        for (int i = 0; i < 10 * FR && !seen; i++) begin
            tick();
            checks++; if (o_lock !== m_locked) begin errors++; if (errors < 20) $display("FAIL lock_state cyc %0d got %b exp %b", ecnt, o_lock, m_locked); end
            checks++; if (o_blank !== exp_blank) begin errors++; if (errors < 20) $display("FAIL lock_blank cyc %0d got %b exp %b", ecnt, o_blank, exp_blank); end
            if (m_locked) seen = 1;
        end
        checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL lock_reached got %b exp 1", o_lock); end
    endtask

    task automatic test_pattern();
        int nb = 0;
        tp = 1;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            if (!o_blank) nb++;
            checks++; if (o_blank !== exp_blank) begin errors++; if (errors < 20) $display("FAIL pat_blank h%0d v%0d got %b exp %b", last_hc, last_vc, o_blank, exp_blank); end
            checks++; if ({o_r, o_g, o_b} !== {exp_r, exp_g, exp_b}) begin errors++; if (errors < 20) $display("FAIL pat_rgb h%0d v%0d got %h exp %h", last_hc, last_vc, {o_r, o_g, o_b}, {exp_r, exp_g, exp_b}); end
            if (o_blank) begin
                checks++; if ({o_r, o_g, o_b} !== 24'h0) begin errors++; if (errors < 20) $display("FAIL pat_blank_rgb got %h exp 000000", {o_r, o_g, o_b}); end
            end
        end
        checks++; if (nb !== 2 * HA * VA) begin errors++; $display("FAIL pat_active_count got %0d exp %0d", nb, 2 * HA * VA); end
    endtask

    task automatic test_sync();
        int hl = 0, vl = 0;
        for (int i = 0; i < FR; i++) begin
            tick();
            if (!o_hs) hl++;
            if (!o_vs) vl++;
            checks++; if (o_hs !== exp_hs) begin errors++; if (errors < 20) $display("FAIL sync_h h%0d v%0d got %b exp %b", last_hc, last_vc, o_hs, exp_hs); end
            checks++; if (o_vs !== exp_vs) begin errors++; if (errors < 20) $display("FAIL sync_v h%0d v%0d got %b exp %b", last_hc, last_vc, o_vs, exp_vs); end
        end
        checks++; if (hl !== VT * (HT - HS)) begin errors++; $display("FAIL sync_h_low got %0d exp %0d", hl, VT * (HT - HS)); end
        checks++; if (vl !== (VT - VS) * HT) begin errors++; $display("FAIL sync_v_low got %0d exp %0d", vl, (VT - VS) * HT); end
    endtask

    task automatic test_passthrough();
        tp = 0;
        for (int i = 0; i < FR; i++) begin
            tick();
            checks++; if ({o_r, o_g, o_b} !== {exp_r, exp_g, exp_b}) begin errors++; if (errors < 20) $display("FAIL pass_rgb h%0d v%0d got %h exp %h", last_hc, last_vc, {o_r, o_g, o_b}, {exp_r, exp_g, exp_b}); end
            checks++; if (o_blank !== exp_blank) begin errors++; if (errors < 20) $display("FAIL pass_blank got %b exp %b", o_blank, exp_blank); end
        end
    endtask

    task automatic test_instability();
        bit dropped = 0, relocked = 0;
        short_next = 1;
        for (int i = 0; i < 8 * FR; i++) begin
            tick();
            if (!o_lock) dropped = 1;
            if (dropped && o_lock) relocked = 1;
            checks++; if (o_lock !== m_locked) begin errors++; if (errors < 20) $display("FAIL unst_lock cyc %0d got %b exp %b", ecnt, o_lock, m_locked); end
            checks++; if (o_blank !== exp_blank) begin errors++; if (errors < 20) $display("FAIL unst_blank cyc %0d got %b exp %b", ecnt, o_blank, exp_blank); end
        end
        checks++; if (!dropped) begin errors++; $display("FAIL unst_drop got 0 exp 1"); end
        checks++; if (!relocked) begin errors++; $display("FAIL unst_relock got 0 exp 1"); end
    endtask

    task automatic test_reset_midframe();
        bit seen = 0;
        tp = 1;
        for (int i = 0; i < 2 * HT && !(last_hc == 10 && last_vc == 5); i++) tick();
        for (int i = 0; i < FR && !(last_hc == 10 && last_vc == 5); i++) tick();
        #3 rst_n = 0;
        #1;
        checks++; if ({o_blank, o_hs, o_vs, o_lock} !== 4'b1110) begin errors++; $display("FAIL mid_reset_ctl got %b exp 1110", {o_blank, o_hs, o_vs, o_lock}); end
        checks++; if ({o_r, o_g, o_b} !== 24'h0) begin errors++; $display("FAIL mid_reset_rgb got %h exp 000000", {o_r, o_g, o_b}); end
        rst_cycle(); rst_cycle();
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 8 * FR && !seen; i++) begin
            tick();
            if (m_locked) seen = 1;
            checks++; if ({o_blank, o_hs, o_vs, o_lock} !== {exp_blank, exp_hs, exp_vs, m_locked}) begin errors++; if (errors < 20) $display("FAIL mid_ctl cyc %0d got %b exp %b", ecnt, {o_blank, o_hs, o_vs, o_lock}, {exp_blank, exp_hs, exp_vs, m_locked}); end
            checks++; if ({o_r, o_g, o_b} !== {exp_r, exp_g, exp_b}) begin errors++; if (errors < 20) $display("FAIL mid_rgb got %h exp %h", {o_r, o_g, o_b}, {exp_r, exp_g, exp_b}); end
        end
        checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL mid_relock got %b exp 1", o_lock); end
    endtask

    task automatic test_no_hsync();
        no_hs = 1;
        drive_src();
        for (int i = 0; i < 1100; i++) begin
            tick();
            checks++; if ({o_blank, o_hs, o_vs} !== {exp_blank, exp_hs, exp_vs}) begin errors++; if (errors < 20) $display("FAIL nohs_ctl h%0d got %b exp %b", last_hc, {o_blank, o_hs, o_vs}, {exp_blank, exp_hs, exp_vs}); end
        end
        checks++; if (o_hs !== 1'b0) begin errors++; $display("FAIL nohs_hsync_low got %b exp 0", o_hs); end
        checks++; if (o_blank !== 1'b1) begin errors++; $display("FAIL nohs_blank got %b exp 1", o_blank); end
        no_hs = 0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pattern();
        test_sync();
        test_passthrough();
        test_instability();
        test_reset_midframe();
        test_no_hsync();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
